// File: rtl/alu_seq.sv
// Multi-cycle EX-stage ALU with ready/valid handshakes; HAMD iterates CHUNK bits per cycle.
// Define ALU_MUL_EN to add the iterative shift-add multiplier on opcode 1011.
//   state | meaning
//   IDLE  | waiting for an op, in_ready high
//   ITER  | HAMD popcount, CHUNK bits per cycle
//   MUL   | shift-add multiply, one bit per cycle (ALU_MUL_EN only)
//   DONE  | s/z valid, waiting for out_ready
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             busy
);

  localparam int SW   = $clog2(WIDTH);
  localparam int AW   = SW + 1;
  localparam int NCH  = WIDTH / CHUNK;
  localparam int HALF = WIDTH / 2;
  localparam logic [SW-1:0] LAST_CHUNK = SW'(NCH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd3;
`ifdef ALU_MUL_EN
  localparam logic [1:0] MUL  = 2'd2;
  localparam logic [SW-1:0] LAST_BIT = SW'(WIDTH - 1);
`endif

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic             z_q, z_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [SW-1:0]    cnt_q, cnt_d;
`ifdef ALU_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] macc_q, macc_d;
  logic [WIDTH-1:0] prod;
`endif

  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] res;
  logic             is_hamd;
  logic             is_mul;
  logic [AW-1:0]    acc_sum;

  function automatic logic [AW-1:0] popcnt(input logic [CHUNK-1:0] v);
    logic [AW-1:0] c;
    c = '0;
    for (int i = 0; i < CHUNK; i++) c = c + AW'(v[i]);
    return c;
  endfunction

  assign shamt   = a[SW-1:0];
  assign acc_sum = acc_q + popcnt(shreg_q[CHUNK-1:0]);

  // Decode order matters: the x-patterns overlap only where the opcode table says so.
  always_comb begin
    res     = '0;
    is_hamd = 1'b0;
    is_mul  = 1'b0;
    casez (aluc)
      4'b?000: res = a + b;
      4'b?100: res = a - b;
      4'b0001: res = a & b;
      4'b?101: res = a | b;
      4'b?010: res = a ^ b;
      4'b?110: res = b << HALF;
      4'b1001: is_hamd = 1'b1;
      4'b0011: res = b << shamt;
      4'b0111: res = b >> shamt;
      4'b1111: res = $unsigned($signed(b) >>> shamt);
`ifdef ALU_MUL_EN
      4'b1011: is_mul = 1'b1;
`endif
      default: res = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  assign prod = mplier_q[0] ? (macc_q + mcand_q) : macc_q;
`endif

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    z_d     = z_q;
    shreg_d = shreg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
`ifdef ALU_MUL_EN
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    macc_d   = macc_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (is_hamd) begin
            shreg_d = a ^ b;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ITER;
          end else if (is_mul) begin
`ifdef ALU_MUL_EN
            mcand_d  = a;
            mplier_d = b;
            macc_d   = '0;
            cnt_d    = '0;
            state_d  = MUL;
`endif
          end else begin
            s_d     = res;
            z_d     = (res == '0);
            state_d = DONE;
          end
        end
      end
      ITER: begin
        acc_d   = acc_sum;
        shreg_d = shreg_q >> CHUNK;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST_CHUNK) begin
          s_d     = WIDTH'(acc_sum);
          z_d     = (acc_sum == '0);
          state_d = DONE;
        end
      end
`ifdef ALU_MUL_EN
      MUL: begin
        macc_d   = prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == LAST_BIT) begin
          s_d     = prod;
          z_d     = (prod == '0);
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      s_q     <= '0;
      z_q     <= 1'b0;
      shreg_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
`ifdef ALU_MUL_EN
      mcand_q  <= '0;
      mplier_q <= '0;
      macc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      z_q     <= z_d;
      shreg_q <= shreg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
`ifdef ALU_MUL_EN
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      macc_q   <= macc_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign z         = z_q;
`ifdef ALU_MUL_EN
  assign busy = (state_q == ITER) || (state_q == MUL);
`else
  assign busy = (state_q == ITER);
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=32, CHUNK=8) with an expected-result queue.
// Follows ALU_MUL_EN to pick the expected outcome of opcode 1011.
module tb_alu_seq;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   aluc = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] s;
  logic         z;
  logic         busy;

  int tests = 0;
  int fails = 0;
  logic [W:0] sbq[$];

  alu_seq #(.WIDTH(W), .CHUNK(8)) dut (
    .clock(clock), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .aluc(aluc), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .z(z), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] es, input logic ez);
    int g = 0;
    while (!in_ready && g < 100) begin @(posedge clock); #1; g++; end
    check("in_ready_before_send", in_ready, 1);
    aluc = op; a = av; b = bv; in_valid = 1'b1;
    sbq.push_back({ez, es});
    @(posedge clock); #1;
    // scramble inputs after the accept edge; the DUT must not resample them
    in_valid = 1'b0; a = ~av; b = bv ^ 32'h5A5A_A5A5; aluc = ~op;
  endtask

  task automatic collect(input string tag, input int exp_lat);
    int lat = 0;
    int bsy = 0;
    logic [W:0] e;
    while (!out_valid && lat < 100) begin
      bsy += busy;
      @(posedge clock); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bsy, exp_lat);
    e = (sbq.size() > 0) ? sbq.pop_front() : {(W+1){1'bx}};
    check({tag, "_s"}, s, e[W-1:0]);
    check({tag, "_z"}, z, e[W]);
  endtask

  task automatic release_out(input string tag);
    @(posedge clock); #1;
    check({tag, "_back_to_idle"}, in_ready, 1);
    check({tag, "_out_valid_low"}, out_valid, 0);
  endtask

  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                       input logic [W-1:0] bv, input logic [W-1:0] es, input logic ez, input int lat);
    send(op, av, bv, es, ez);
    collect(tag, lat);
    release_out(tag);
  endtask

  initial begin
    #1;
    check("rst_s", s, 0);
    check("rst_z", z, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    #11 resetn = 1'b1;
    @(posedge clock); #1;

    do_op("add_wrap",  4'b0000, 32'h7FFF_FFFF, 32'h1,          32'h8000_0000, 1'b0, 0);
    do_op("sub_zero",  4'b0100, 32'h5,         32'h5,          32'h0,         1'b1, 0);
    do_op("add_alt",   4'b1000, 32'h3,         32'h4,          32'h7,         1'b0, 0);
    do_op("sub_wrap",  4'b1100, 32'h0,         32'h1,          32'hFFFF_FFFF, 1'b0, 0);
    do_op("and",       4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00,  32'hF000_F000, 1'b0, 0);
    do_op("or",        4'b0101, 32'hF0F0_F0F0, 32'h0F0F_0000,  32'hFFFF_F0F0, 1'b0, 0);
    do_op("or_alt",    4'b1101, 32'h1,         32'h2,          32'h3,         1'b0, 0);
    do_op("xor",       4'b0010, 32'hFFFF_0000, 32'h0F0F_0F0F,  32'hF0F0_0F0F, 1'b0, 0);
    do_op("hamd_all",  4'b1001, 32'hFFFF_0000, 32'h0000_FFFF,  32'd32,        1'b0, 4);
    do_op("hamd_eq",   4'b1001, 32'h1234_5678, 32'h1234_5678,  32'd0,         1'b1, 4);
    do_op("hamd_top",  4'b1001, 32'hF000_0001, 32'h0000_0003,  32'd5,         1'b0, 4);
    do_op("sra",       4'b1111, 32'd36,        32'h8000_0000,  32'hF800_0000, 1'b0, 0);
    do_op("srl",       4'b0111, 32'd36,        32'h8000_0000,  32'h0800_0000, 1'b0, 0);
    do_op("lui",       4'b0110, 32'h0,         32'h0000_1234,  32'h1234_0000, 1'b0, 0);
`ifdef ALU_MUL_EN
    do_op("mul",       4'b1011, 32'h0001_0001, 32'h0001_0001,  32'h0002_0001, 1'b0, 32);
`else
    do_op("mul_off",   4'b1011, 32'h0001_0001, 32'h0001_0001,  32'h0,         1'b1, 0);
`endif

    out_ready = 1'b0;
    send(4'b0011, 32'h4, 32'h1, 32'h10, 1'b0);
    collect("sll", 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; aluc = 4'b0000; a = 32'h1; b = 32'h1;
      @(posedge clock); #1;
      check("bp_s_held", s, 32'h10);
      check("bp_out_valid", out_valid, 1);
      check("bp_in_ready_low", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    release_out("bp");
    check("bp_s_after_idle", s, 32'h10);

    send(4'b1001, 32'hFFFF_0000, 32'h0000_FFFF, 32'd32, 1'b0);
    @(posedge clock); #1;
    check("mid_hamd_busy", busy, 1);
    resetn = 1'b0;
    #1;
    sbq.delete();
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_s", s, 0);
    check("midrst_z", z, 0);
    check("midrst_busy", busy, 0);
    #2 resetn = 1'b1;
    @(posedge clock); #1;
    do_op("add_after_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 0);

    check("scoreboard_empty", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
